// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline,
// with data-memory wait sequencing, timeout fault and saturating debug counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regWrite,
    input  logic [1:0]       ex_resultSrc,
    input  logic             ex_pcSrc,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regWrite,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regWrite,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
    state_t           r_state;
    state_t           w_eff;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_freeze;
    logic             w_ctrl;
    logic             w_lu_match;
    logic             w_lu;
    // The reset cycle is evaluated as if already in RUN.
    assign w_eff      = reset ? RUN : r_state;
    assign w_freeze   = (w_eff == FAULT) || (!dmem_ready && ((w_eff == MEM_WAIT) || mem_req));
    assign w_ctrl     = !w_freeze && ex_pcSrc;
    assign w_lu_match = ex_regWrite && (ex_resultSrc == 2'b01) && (ex_rd != '0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign w_lu       = !w_freeze && !ex_pcSrc && w_lu_match;
    assign pc_en        = !w_freeze && !w_lu;
    assign if_id_en     = !w_freeze && !w_lu;
    assign if_id_flush  = w_ctrl;
    assign id_ex_en     = !w_freeze;
    assign id_ex_flush  = w_ctrl || w_lu;
    assign ex_mem_en    = !w_freeze;
    assign mem_wb_flush = w_freeze;
    assign mem_fault    = (w_eff == FAULT);
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign fwd_a_sel = (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs1)) ? 2'b10 :
                       (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs1)) ? 2'b01 : 2'b00;
    assign fwd_b_sel = (mem_regWrite && (mem_rd != '0) && (mem_rd == ex_rs2)) ? 2'b10 :
                       (wb_regWrite && (wb_rd != '0) && (wb_rd == ex_rs2)) ? 2'b01 : 2'b00;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_ctrl && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            case (r_state)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WW'(MEM_TIMEOUT)) begin
                        r_state <= FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                default: r_state <= FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table plus multi-cycle sequences
// for forwarding, load-use, control flush, memory wait/timeout and counters.
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic [3:0] id_rs1;
        logic [3:0] id_rs2;
        logic       u1;
        logic       u2;
        logic [3:0] ex_rs1;
        logic [3:0] ex_rs2;
        logic [3:0] ex_rd;
        logic       ex_rw;
        logic [1:0] ex_rs;
        logic       pcsrc;
        logic [3:0] mem_rd;
        logic       mem_rw;
        logic       mem_req;
        logic       ready;
        logic [3:0] wb_rd;
        logic       wb_rw;
    } in_t;
    typedef struct {
        in_t        i;
        logic [6:0] c;
        logic [1:0] a;
        logic [1:0] b;
    } vec_t;
    // ctl order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    localparam logic [6:0] N = 7'b1101010;
    localparam logic [6:0] S = 7'b0001110;
    localparam logic [6:0] F = 7'b1111110;
    localparam logic [6:0] Z = 7'b0000001;
    logic       clk = 0;
    logic       reset = 1;
    in_t        din;
    in_t        base;
    in_t        x;
    vec_t       tbl[$];
    int         checks = 0;
    int         errors = 0;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_fault;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [3:0] stall_cnt, flush_cnt;
    pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(din.id_rs1), .id_rs2(din.id_rs2),
        .id_uses_rs1(din.u1), .id_uses_rs2(din.u2),
        .ex_rs1(din.ex_rs1), .ex_rs2(din.ex_rs2), .ex_rd(din.ex_rd),
        .ex_regWrite(din.ex_rw), .ex_resultSrc(din.ex_rs), .ex_pcSrc(din.pcsrc),
        .mem_rd(din.mem_rd), .mem_regWrite(din.mem_rw), .mem_req(din.mem_req),
        .dmem_ready(din.ready), .wb_rd(din.wb_rd), .wb_regWrite(din.wb_rw),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask
    task automatic chk_out(input string n, input logic [6:0] c, input logic [1:0] a, input logic [1:0] b);
        chk({n, " ctl"}, 16'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}), 16'(c));
        chk({n, " fwd_a"}, 16'(fwd_a_sel), 16'(a));
        chk({n, " fwd_b"}, 16'(fwd_b_sel), 16'(b));
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1;
        din = base;
        tick();
        tick();
        reset = 0;
    endtask
    task automatic add(input in_t i, input logic [6:0] c, input logic [1:0] a, input logic [1:0] b);
        vec_t v;
        v.i = i; v.c = c; v.a = a; v.b = b;
        tbl.push_back(v);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        base = '0;
        base.ready = 1;
        x = base; add(x, N, 2'd0, 2'd0);
        x = base; x.mem_rd = 5; x.mem_rw = 1; x.wb_rd = 5; x.wb_rw = 1; x.ex_rs2 = 5; add(x, N, 2'd0, 2'd2);
        x.mem_rd = 0; add(x, N, 2'd0, 2'd1);
        x.ex_rs2 = 0; x.wb_rd = 0; add(x, N, 2'd0, 2'd0);
        x = base; x.mem_rd = 7; x.wb_rd = 7; x.wb_rw = 1; x.ex_rs1 = 7; add(x, N, 2'd1, 2'd0);
        x.mem_rw = 1; x.ex_rs2 = 7; add(x, N, 2'd2, 2'd2);
        x = base; x.ex_rd = 3; x.ex_rw = 1; x.ex_rs = 1; x.id_rs1 = 3; x.u1 = 1; add(x, S, 2'd0, 2'd0);
        x.u1 = 0; x.id_rs2 = 3; add(x, N, 2'd0, 2'd0);
        x.u2 = 1; add(x, S, 2'd0, 2'd0);
        x.ex_rs = 0; add(x, N, 2'd0, 2'd0);
        x.ex_rs = 1; x.ex_rd = 0; x.id_rs2 = 0; add(x, N, 2'd0, 2'd0);
        x.ex_rd = 3; x.id_rs2 = 3; x.pcsrc = 1; add(x, F, 2'd0, 2'd0);
        x.pcsrc = 0; x.ex_rw = 0; add(x, N, 2'd0, 2'd0);

        do_reset();
        chk("reset stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset flush_cnt", 16'(flush_cnt), 16'd0);
        chk("reset mem_fault", 16'(mem_fault), 16'd0);
        for (int k = 0; k < tbl.size(); k++) begin
            din = tbl[k].i;
            #2;
            chk_out($sformatf("vec%0d", k), tbl[k].c, tbl[k].a, tbl[k].b);
            tick();
        end
        chk("table stall_cnt", 16'(stall_cnt), 16'd2);
        chk("table flush_cnt", 16'(flush_cnt), 16'd1);

        do_reset();
        x = base; x.ex_rd = 3; x.ex_rw = 1; x.ex_rs = 1; x.id_rs1 = 3; x.u1 = 1;
        din = x; #2; chk_out("lu stall", S, 2'd0, 2'd0); tick();
        chk("lu stall_cnt", 16'(stall_cnt), 16'd1);
        x = base; x.mem_rd = 3; x.mem_rw = 1; x.ex_rs1 = 3;
        din = x; #2; chk_out("lu resolve", N, 2'd2, 2'd0); tick();
        chk("lu stall_cnt after", 16'(stall_cnt), 16'd1);

        do_reset();
        x = base; x.mem_req = 1; x.ready = 0;
        for (int k = 0; k < 3; k++) begin
            x.pcsrc = (k == 1);
            din = x; #2; chk_out($sformatf("freeze%0d", k), Z, 2'd0, 2'd0); tick();
        end
        x.pcsrc = 0; x.ready = 1;
        din = x; #2; chk_out("freeze release", N, 2'd0, 2'd0); tick();
        chk("freeze stall_cnt", 16'(stall_cnt), 16'd3);
        chk("freeze flush_cnt", 16'(flush_cnt), 16'd0);
        x = base; x.ready = 0;
        din = x; #2; chk_out("back in run", N, 2'd0, 2'd0);
        chk("freeze mem_fault", 16'(mem_fault), 16'd0);
        tick();

        do_reset();
        x = base; x.mem_req = 1; x.ready = 0;
        din = x; tick();
        din = x; tick();
        reset = 1; x.mem_req = 0;
        din = x; #2; chk_out("reset in wait", N, 2'd0, 2'd0); tick();
        reset = 0;
        #1; chk_out("run after wait reset", N, 2'd0, 2'd0);
        chk("wait reset stall_cnt", 16'(stall_cnt), 16'd0);
        tick();

        do_reset();
        x = base; x.mem_req = 1; x.ready = 0;
        din = x;
        for (int k = 0; k < 16; k++) begin
            #2;
            if (k == 0 || k == 15) begin
                chk_out($sformatf("timeout%0d", k), Z, 2'd0, 2'd0);
                chk($sformatf("no fault%0d", k), 16'(mem_fault), 16'd0);
            end
            tick();
        end
        chk("fault set", 16'(mem_fault), 16'd1);
        din = base; #2; chk_out("fault hold", Z, 2'd0, 2'd0); tick();
        chk("fault sticky", 16'(mem_fault), 16'd1);
        chk("stall saturate", 16'(stall_cnt), 16'd15);
        reset = 1; din = base; #2; chk_out("reset from fault", N, 2'd0, 2'd0); tick();
        reset = 0;
        #1;
        chk("fault cleared", 16'(mem_fault), 16'd0);
        chk("fault stall_cnt", 16'(stall_cnt), 16'd0);
        chk("fault flush_cnt", 16'(flush_cnt), 16'd0);
        chk_out("run after fault", N, 2'd0, 2'd0);
        tick();

        do_reset();
        for (int k = 1; k <= 18; k++) begin
            x = base; x.pcsrc = 1; din = x; tick();
            din = base; tick();
            if (k == 14) chk("flush_cnt 14", 16'(flush_cnt), 16'd14);
        end
        chk("flush saturate", 16'(flush_cnt), 16'd15);
        chk("flush stall_cnt", 16'(stall_cnt), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
